// File: rtl/store_buffer_if.sv
// MEM-stage / DataMem bundle for the store buffer.
// The slave side is the buffer itself; the master side is the pipeline plus DataMem.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [CW-1:0] sb_count;
  logic          sb_empty;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dout,
    input  cpu_rdata, cpu_stall, mem_wen, mem_addr, mem_din, sb_count, sb_empty
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dout,
    output cpu_rdata, cpu_stall, mem_wen, mem_addr, mem_din, sb_count, sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO in front of single-port DataMem; loads own the port and
// are forwarded from the youngest matching buffered store.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          load, store, full, empty, drain, enq, hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign load  = sb.cpu_req & ~sb.cpu_we;
  assign store = sb.cpu_req &  sb.cpu_we;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign drain = ~empty & ~load;
  assign enq   = store & ~full;

  assign sb.cpu_stall = store & full;
  assign sb.mem_wen   = drain;
  assign sb.mem_addr  = load ? sb.cpu_addr : addr_q[head_q];
  assign sb.mem_din   = data_q[head_q];
  assign sb.sb_count  = count_q;
  assign sb.sb_empty  = empty;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == sb.cpu_addr)) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign sb.cpu_rdata = hit ? fwd_data : sb.mem_dout;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PW'(1);
    if (enq)   tail_d = tail_q + PW'(1);
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset: validity is derived from head/count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= sb.cpu_addr;
      data_q[tail_q] <= sb.cpu_wdata;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a queue-based reference
// model and a shadow copy of DataMem.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 9;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  always #5 clk = ~clk;

  // DataMem: combinational read, write on posedge
  logic [DW-1:0] dmem [0:511];
  logic [DW-1:0] rmem [0:511];
  assign sb_if.mem_dout = dmem[sb_if.mem_addr];
  always @(posedge clk) if (sb_if.mem_wen) dmem[sb_if.mem_addr] <= sb_if.mem_din;

  ent_t act_log[$];
  always @(posedge clk) if (rst_n && sb_if.mem_wen) act_log.push_back('{sb_if.mem_addr, sb_if.mem_din});

  ent_t q[$];
  logic [DW-1:0] obs_rd, obs_din;
  logic [AW-1:0] obs_addr;
  logic          obs_wen, obs_stall, obs_empty;
  int            stall_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ld, st, exp_stall, exp_wen;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    sb_if.cpu_req   = req;
    sb_if.cpu_we    = we;
    sb_if.cpu_addr  = a;
    sb_if.cpu_wdata = d;
    ld = req && !we;
    st = req && we;
    exp_stall = st && (q.size() == DEPTH);
    exp_wen   = (q.size() != 0) && !ld;
    #1;
    obs_rd    = sb_if.cpu_rdata;
    obs_din   = sb_if.mem_din;
    obs_addr  = sb_if.mem_addr;
    obs_wen   = sb_if.mem_wen;
    obs_stall = sb_if.cpu_stall;
    obs_empty = sb_if.sb_empty;
    if (obs_stall) stall_seen++;
    chk("stall", 32'(obs_stall), 32'(exp_stall));
    chk("mem_wen", 32'(obs_wen), 32'(exp_wen));
    chk("sb_count", 32'(sb_if.sb_count), 32'(q.size()));
    chk("sb_empty", 32'(obs_empty), 32'(q.size() == 0));
    if (ld) begin
      exp_rd = rmem[a];
      foreach (q[i]) if (q[i].a == a) exp_rd = q[i].d;
      chk("rdata", obs_rd, exp_rd);
      chk("mem_addr_ld", 32'(obs_addr), 32'(a));
    end else if (exp_wen) begin
      chk("mem_addr_wr", 32'(obs_addr), 32'(q[0].a));
      chk("mem_din", obs_din, q[0].d);
    end
    @(posedge clk);
    if (exp_wen) begin
      rmem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (st && !exp_stall) q.push_back('{a, d});
  endtask

  initial begin
    ent_t iss[$];
    int   mism;
    for (int i = 0; i < 512; i++) begin
      dmem[i] = 32'(i) * 32'h9e3779b9;
      rmem[i] = 32'(i) * 32'h9e3779b9;
    end
    dmem[0] = 32'h3243f6a8;
    rmem[0] = 32'h3243f6a8;
    sb_if.cpu_req = 0; sb_if.cpu_we = 0; sb_if.cpu_addr = '0; sb_if.cpu_wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(sb_if.sb_count), 0);
    chk("rst_empty", 32'(sb_if.sb_empty), 1);
    chk("rst_wen", 32'(sb_if.mem_wen), 0);
    chk("rst_stall", 32'(sb_if.cpu_stall), 0);
    rst_n = 1'b1;

    // load miss on empty buffer returns DataMem contents
    cycle(1, 0, 0, 0);
    chk("t4_rdata", obs_rd, 32'h3243f6a8);
    chk("t4_addr", 32'(obs_addr), 0);

    cycle(1, 1, 5, 32'hdeadbeef);
    cycle(0, 0, 0, 0);
    chk("t2_wen", 32'(obs_wen), 1);
    chk("t2_addr", 32'(obs_addr), 5);
    chk("t2_din", obs_din, 32'hdeadbeef);
    cycle(0, 0, 0, 0);
    chk("t2_empty", 32'(obs_empty), 1);

    cycle(1, 1, 5, 32'h11111111);
    cycle(1, 1, 5, 32'h22222222);
    cycle(1, 0, 5, 0);
    chk("t3_rdata", obs_rd, 32'h22222222);
    chk("t3_wen", 32'(obs_wen), 0);
    repeat (2) cycle(0, 0, 0, 0);
    chk("t3_dmem5", dmem[5], 32'h22222222);

    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, AW'(200 + i), $urandom);
      cycle(1, 0, AW'(200 + i), 0);
    end
    cycle(1, 1, 204, $urandom);
    cycle(1, 1, 204, $urandom);
    repeat (3) cycle(0, 0, 0, 0);

    // back-to-back stores: ordering of retirement
    act_log.delete();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ent_t e;
      e.a = AW'(32 + i);
      e.d = $urandom;
      iss.push_back(e);
      cycle(1, 1, e.a, e.d);
    end
    repeat (2) cycle(0, 0, 0, 0);
    chk("t6_nwrites", 32'(act_log.size()), 32'(iss.size()));
    for (int i = 0; i < iss.size() && i < act_log.size(); i++) begin
      chk("t6_order_addr", 32'(act_log[i].a), 32'(iss[i].a));
      chk("t6_order_data", act_log[i].d, iss[i].d);
    end

    for (int n = 0; n < 300; n++) begin
      logic r, w;
      r = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      cycle(r, w, AW'($urandom_range(0, 15)), $urandom);
    end

    // reset mid-traffic discards buffered stores
    cycle(1, 1, 100, 32'hcafef00d);
    @(negedge clk);
    sb_if.cpu_req = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t1_count", 32'(sb_if.sb_count), 0);
    chk("t1_empty", 32'(sb_if.sb_empty), 1);
    chk("t1_wen", 32'(sb_if.mem_wen), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 0, 0);
    chk("t1_no_late_write", dmem[100], rmem[100]);

    mism = 0;
    for (int i = 0; i < 512; i++) if (dmem[i] !== rmem[i]) mism++;
    chk("dmem_match", 32'(mism), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
